rc5_key_sched_ctrl: RTL and testbench
=====================================

Name: rc5_key_sched_ctrl

Overview:
- Sequences the full RC5 key schedule around the key mixer.
- Accepts C secret-key words into the L table and fills the S table with the magic-constant progression. Then resets and starts the mixer and waits for its done.
- Owns the S/L RAM port mux: the controller drives the RAMs in setup states; the mixer drives them during mixing.
- Raises a ready flag for the encrypt/decrypt datapath once the S table is final.

Parameters:
- W, 32, word width.
- C, 4, key words in L table.
- T, 26, S table entries (2r+2).
- P_W, 32'hB7E15163, RC5 P constant.
- Q_W, 32'h9E3779B9, RC5 Q constant.
- WDOG_CYCLES, 1024, mixer timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- iRekey  in  1  request a new key schedule (pulse).
- iKeyValid  in  1  key word valid.
- iKeyWord  in  W  key word, L[0] first.
- oKeyReady  out  1  ready to accept a key word.
- oL_we  out  1  L RAM write enable (controller side).
- oL_address  out  2  L RAM address.
- oL_data  out  W  L RAM write data.
- oS_we  out  1  S RAM write enable (controller side).
- oS_address  out  $clog2(T)  S RAM address.
- oS_data  out  W  S RAM write data.
- oMemSel  out  1  RAM mux select: 0 = controller, 1 = mixer.
- oMixRst  out  1  synchronous-style reset pulse to the mixer.
- oMixStart  out  1  mixer iStart.
- iMixDone  in  1  mixer oDone (level, sticky until mixer reset).
- oSchedReady  out  1  S table valid for the cipher.
- oErr  out  1  mixer timeout flag.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Outputs: all registered.
- Reset (any state, including mid-schedule): state=IDLE; every output 0; counters i=0, j=0; accumulator=P_W.
- State IDLE:
  - iRekey=1 -> LOAD_L next cycle.
  - Otherwise stay.
- State LOAD_L:
  - oKeyReady=1.
  - Each cycle with iKeyValid&oKeyReady: on the next cycle oL_we=1, oL_address=j, oL_data=iKeyWord; j increments.
  - After the C-th accepted word, oKeyReady drops the following cycle -> INIT_S.
  - iKeyValid while oKeyReady=0 is ignored.
- State INIT_S:
  - Exactly T cycles, one write per cycle: oS_we=1, oS_address=i, oS_data=acc.
  - acc starts at P_W; acc<=acc+Q_W, modulo 2^W (wrap, no saturation).
  - After i=T-1 -> MIX_RST.
- State MIX_RST: oMixRst=1 for one cycle; oMemSel=1 from this state on -> START_MIX.
- State START_MIX: oMixStart=1 for one cycle -> WAIT_MIX.
- State WAIT_MIX: hold oMemSel=1; iMixDone=1 -> READY.
- State READY:
  - oSchedReady=1, oMemSel=0.
  - iRekey -> LOAD_L; oSchedReady=0 from the next cycle; j, i and acc reinitialised.
- iRekey in LOAD_L/INIT_S/MIX_RST/START_MIX/WAIT_MIX: ignored; no restart.
- Controller-side we signals are 0 outside LOAD_L/INIT_S writes.
- Minimum latency, iRekey to oSchedReady (keys presented back-to-back): 1 + C + 1 + T + 2 + mixer time + 1 cycles.
- iMixDone already high when entering WAIT_MIX: not possible, because MIX_RST clears it; sampling is only done in WAIT_MIX.

Optional Feature:
- Macro: KEYSCHED_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT_MIX.
  - If it reaches WDOG_CYCLES without iMixDone: -> IDLE, oMemSel=0, oErr=1.
  - oErr is sticky until the next accepted iRekey or rst.
- Undefined: WAIT_MIX waits indefinitely; oErr is tied to 0; no counter logic.

Decomposition:
- Shared package rc5_pkg holds:
  - P_W and Q_W constants.
  - State encodings (IDLE, LOAD_L, INIT_S, MIX_RST, START_MIX, WAIT_MIX, READY).
  - T_LENGTH/C_LENGTH width helpers, so the mixer and cipher share them.
- One natural sub-module: rc5_s_init_gen (accumulator + index counter producing P+i*Q with write strobe); instantiated by the controller.

Test Plan:
- Reset, then iRekey; key words 0x0 x4 -> L writes addr 0..3 data 0; S[0]=B7E15163, S[1]=5618CB1C, S[25]=2B4C3474; oMixRst then oMixStart single-cycle pulses, in order.
- Mixer model raises iMixDone 300 cycles after start -> oSchedReady=1 one cycle later; oMemSel goes 1->0 at the same edge.
- iKeyValid toggled every other cycle -> exactly 4 L writes, addresses 0..3 in order; oKeyReady low afterwards.
- iRekey asserted during INIT_S -> ignored, schedule completes; iRekey in READY -> oSchedReady=0 next cycle and new L writes begin.
- rst asserted mid INIT_S (i=10) -> all outputs 0 immediately; a fresh iRekey restarts at S[0]=B7E15163.
- With KEYSCHED_WATCHDOG_EN and WDOG_CYCLES=16, iMixDone held 0 -> state IDLE after 16 cycles in WAIT_MIX, oErr=1 until the next iRekey.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared RC5 definitions: magic constants, default table sizes, index widths
// and the key-schedule controller state encoding.
package rc5_pkg;

  localparam logic [31:0] P_W = 32'hB7E15163;
  localparam logic [31:0] Q_W = 32'h9E3779B9;

  localparam int C_WORDS  = 4;
  localparam int T_WORDS  = 26;
  localparam int C_LENGTH = $clog2(C_WORDS);
  localparam int T_LENGTH = $clog2(T_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_L,
    INIT_S,
    MIX_RST,
    START_MIX,
    WAIT_MIX,
    READY
  } ks_state_e;

endpackage

// File: rtl/rc5_s_init_gen.sv
// S-table initialiser: emits one registered write per step with
// address i and data P + i*Q (mod 2^W), built incrementally.
module rc5_s_init_gen
  import rc5_pkg::*;
#(
  parameter int             W   = 32,
  parameter int             T   = T_WORDS,
  parameter logic [W-1:0]   P_W = rc5_pkg::P_W,
  parameter logic [W-1:0]   Q_W = rc5_pkg::Q_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iClear,
  input  logic                 iStep,
  output logic                 oWe,
  output logic [$clog2(T)-1:0] oAddr,
  output logic [W-1:0]         oData,
  output logic                 oLast
);

  localparam int AW = $clog2(T);

  logic [AW-1:0] i_q, i_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;

  always_comb begin
    i_d    = i_q;
    acc_d  = acc_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (iClear) begin
      i_d   = '0;
      acc_d = P_W;
    end else if (iStep) begin
      we_d   = 1'b1;
      addr_d = i_q;
      data_d = acc_q;
      i_d    = i_q + 1'b1;
      acc_d  = acc_q + Q_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      acc_q  <= P_W;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      i_q    <= i_d;
      acc_q  <= acc_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign oWe   = we_q;
  assign oAddr = addr_q;
  assign oData = data_q;
  assign oLast = (i_q == AW'(T - 1));

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key-schedule sequencer: loads L, initialises S, runs the mixer, flags ready.
// Optional mixer watchdog enabled by defining KEYSCHED_WATCHDOG_EN.
module rc5_key_sched_ctrl
  import rc5_pkg::*;
#(
  parameter int           W           = 32,
  parameter int           C           = C_WORDS,
  parameter int           T           = T_WORDS,
  parameter logic [W-1:0] P_W         = rc5_pkg::P_W,
  parameter logic [W-1:0] Q_W         = rc5_pkg::Q_W,
  parameter int           WDOG_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iRekey,
  input  logic                 iKeyValid,
  input  logic [W-1:0]         iKeyWord,
  output logic                 oKeyReady,
  output logic                 oL_we,
  output logic [1:0]           oL_address,
  output logic [W-1:0]         oL_data,
  output logic                 oS_we,
  output logic [$clog2(T)-1:0] oS_address,
  output logic [W-1:0]         oS_data,
  output logic                 oMemSel,
  output logic                 oMixRst,
  output logic                 oMixStart,
  input  logic                 iMixDone,
  output logic                 oSchedReady,
  output logic                 oErr
);

  localparam int JW = $clog2(C + 1);

  ks_state_e     state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic          key_ready_q, key_ready_d;
  logic          l_we_q, l_we_d;
  logic [1:0]    l_addr_q, l_addr_d;
  logic [W-1:0]  l_data_q, l_data_d;
  logic          mem_sel_q, mem_sel_d;
  logic          mix_rst_q, mix_rst_d;
  logic          mix_start_q, mix_start_d;
  logic          sched_ready_q, sched_ready_d;
  logic          gen_clear, gen_step, gen_last;

`ifdef KEYSCHED_WATCHDOG_EN
  localparam int WDW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
`endif

  rc5_s_init_gen #(
    .W   (W),
    .T   (T),
    .P_W (P_W),
    .Q_W (Q_W)
  ) u_s_init_gen (
    .clk    (clk),
    .rst    (rst),
    .iClear (gen_clear),
    .iStep  (gen_step),
    .oWe    (oS_we),
    .oAddr  (oS_address),
    .oData  (oS_data),
    .oLast  (gen_last)
  );

  // Outputs are registered from the current state, so each pulse shows up
  // one cycle after its state is entered; the last S write lands before oMemSel rises.
  always_comb begin
    state_d       = state_q;
    j_d           = j_q;
    key_ready_d   = key_ready_q;
    l_we_d        = 1'b0;
    l_addr_d      = l_addr_q;
    l_data_d      = l_data_q;
    mem_sel_d     = mem_sel_q;
    mix_rst_d     = 1'b0;
    mix_start_d   = 1'b0;
    sched_ready_d = sched_ready_q;
    gen_clear     = 1'b0;
    gen_step      = 1'b0;
`ifdef KEYSCHED_WATCHDOG_EN
    wdog_d        = wdog_q;
    err_d         = err_q;
`endif
    case (state_q)
      IDLE, READY: begin
        if (iRekey) begin
          state_d       = LOAD_L;
          key_ready_d   = 1'b1;
          j_d           = '0;
          gen_clear     = 1'b1;
          sched_ready_d = 1'b0;
          mem_sel_d     = 1'b0;
`ifdef KEYSCHED_WATCHDOG_EN
          err_d         = 1'b0;
`endif
        end
      end
      LOAD_L: begin
        if (key_ready_q) begin
          if (iKeyValid) begin
            l_we_d   = 1'b1;
            l_addr_d = j_q[1:0];
            l_data_d = iKeyWord;
            j_d      = j_q + 1'b1;
            if (j_q == JW'(C - 1)) key_ready_d = 1'b0;
          end
        end else begin
          state_d = INIT_S;
        end
      end
      INIT_S: begin
        gen_step = 1'b1;
        if (gen_last) state_d = MIX_RST;
      end
      MIX_RST: begin
        mix_rst_d = 1'b1;
        mem_sel_d = 1'b1;
        state_d   = START_MIX;
      end
      START_MIX: begin
        mix_start_d = 1'b1;
        state_d     = WAIT_MIX;
`ifdef KEYSCHED_WATCHDOG_EN
        wdog_d      = '0;
`endif
      end
      WAIT_MIX: begin
        if (iMixDone) begin
          sched_ready_d = 1'b1;
          mem_sel_d     = 1'b0;
          state_d       = READY;
        end
`ifdef KEYSCHED_WATCHDOG_EN
        else if (wdog_q == WDW'(WDOG_CYCLES - 1)) begin
          mem_sel_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      j_q           <= '0;
      key_ready_q   <= 1'b0;
      l_we_q        <= 1'b0;
      l_addr_q      <= '0;
      l_data_q      <= '0;
      mem_sel_q     <= 1'b0;
      mix_rst_q     <= 1'b0;
      mix_start_q   <= 1'b0;
      sched_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      j_q           <= j_d;
      key_ready_q   <= key_ready_d;
      l_we_q        <= l_we_d;
      l_addr_q      <= l_addr_d;
      l_data_q      <= l_data_d;
      mem_sel_q     <= mem_sel_d;
      mix_rst_q     <= mix_rst_d;
      mix_start_q   <= mix_start_d;
      sched_ready_q <= sched_ready_d;
    end
  end

`ifdef KEYSCHED_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign oErr = err_q;
`else
  assign oErr = 1'b0;
`endif

  assign oKeyReady   = key_ready_q;
  assign oL_we       = l_we_q;
  assign oL_address  = l_addr_q;
  assign oL_data     = l_data_q;
  assign oMemSel     = mem_sel_q;
  assign oMixRst     = mix_rst_q;
  assign oMixStart   = mix_start_q;
  assign oSchedReady = sched_ready_q;

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Bench for rc5_key_sched_ctrl: random keys and mixer latencies against a
// P + i*Q table model, key-order queue and pulse/latency timing rules.
module tb_rc5_key_sched_ctrl;

  localparam int          W   = 32;
  localparam int          C   = 4;
  localparam int          T   = 26;
  localparam int          SAW = $clog2(T);
  localparam logic [31:0] P   = 32'hB7E15163;
  localparam logic [31:0] Q   = 32'h9E3779B9;
`ifdef KEYSCHED_WATCHDOG_EN
  localparam int WDOG = 16;
  localparam int LAT1 = 10;
  localparam int LMIN = 4;
  localparam int LMAX = 12;
`else
  localparam int WDOG = 1024;
  localparam int LAT1 = 300;
  localparam int LMIN = 20;
  localparam int LMAX = 60;
`endif

  logic           clk, rst, iRekey, iKeyValid, iMixDone;
  logic [W-1:0]   iKeyWord;
  logic           oKeyReady, oL_we, oS_we, oMemSel, oMixRst, oMixStart, oSchedReady, oErr;
  logic [1:0]     oL_address;
  logic [W-1:0]   oL_data, oS_data;
  logic [SAW-1:0] oS_address;

  rc5_key_sched_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .iRekey(iRekey), .iKeyValid(iKeyValid), .iKeyWord(iKeyWord),
    .oKeyReady(oKeyReady), .oL_we(oL_we), .oL_address(oL_address), .oL_data(oL_data),
    .oS_we(oS_we), .oS_address(oS_address), .oS_data(oS_data), .oMemSel(oMemSel),
    .oMixRst(oMixRst), .oMixStart(oMixStart), .iMixDone(iMixDone),
    .oSchedReady(oSchedReady), .oErr(oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] keys [C];
  logic [33:0] lq [$];
  logic [36:0] sq [$];
  int rstq [$];
  int startq [$];
  int done_cyc, ready_cyc, fall_cyc, err_cyc;
  int mix_lat = LAT1;
  int mix_cnt = -1;
  bit mix_en = 1'b1;
  bit prev_sel = 1'b0, prev_rdy = 1'b0, prev_err = 1'b0;

  // Mixer model and output recorder, both on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (oMixRst) begin
      iMixDone = 1'b0;
      mix_cnt  = -1;
    end else if (oMixStart) begin
      mix_cnt = mix_lat;
    end else if (mix_cnt > 0) begin
      mix_cnt--;
    end
    if (mix_cnt == 0) begin
      mix_cnt = -1;
      if (mix_en) begin
        iMixDone = 1'b1;
        done_cyc = cyc;
      end
    end
    if (oL_we) lq.push_back({oL_address, oL_data});
    if (oS_we) sq.push_back({oS_address, oS_data});
    if (oMixRst) rstq.push_back(cyc);
    if (oMixStart) startq.push_back(cyc);
    if (prev_sel && !oMemSel) fall_cyc = cyc;
    if (!prev_rdy && oSchedReady) ready_cyc = cyc;
    if (!prev_err && oErr) err_cyc = cyc;
    prev_sel = oMemSel;
    prev_rdy = oSchedReady;
    prev_err = oErr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] s_model(input int i);
    return P + 32'(i) * Q;
  endfunction

  task automatic clear_rec();
    lq.delete();
    sq.delete();
    rstq.delete();
    startq.delete();
    done_cyc = -1; ready_cyc = -1; fall_cyc = -1; err_cyc = -1;
  endtask

  task automatic rekey();
    iRekey = 1'b1;
    tick();
    iRekey = 1'b0;
  endtask

  task automatic load_keys(input bit toggle);
    int k = 0;
    int guard = 0;
    bit ph = 1'b0;
    bit acc;
    while (k < C && guard < 64) begin
      if (toggle && ph) begin
        iKeyValid = 1'b0;
        iKeyWord  = $urandom;
      end else begin
        iKeyValid = 1'b1;
        iKeyWord  = keys[k];
      end
      ph  = !ph;
      acc = iKeyValid && oKeyReady;
      tick();
      if (acc) k++;
      guard++;
    end
    if (k < C) chk("key_load_timeout", 64'(k), 64'(C));
    iKeyValid = 1'b1;
    iKeyWord  = $urandom;
    tick();
    tick();
    iKeyValid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!oSchedReady && g < 2000) begin
      tick();
      g++;
    end
    chk({tag, "_ready"}, 64'(oSchedReady), 64'd1);
  endtask

  task automatic check_sched(input string tag);
    chk({tag, "_lcount"}, 64'(lq.size()), 64'(C));
    for (int k = 0; k < C && k < lq.size(); k++)
      chk($sformatf("%s_l%0d", tag, k), 64'(lq[k]), 64'({2'(k), keys[k]}));
    chk({tag, "_scount"}, 64'(sq.size()), 64'(T));
    for (int i = 0; i < T && i < sq.size(); i++)
      chk($sformatf("%s_s%0d", tag, i), 64'(sq[i]), 64'({SAW'(i), s_model(i)}));
    chk({tag, "_mixrst_pulses"}, 64'(rstq.size()), 64'd1);
    chk({tag, "_start_pulses"}, 64'(startq.size()), 64'd1);
    if (rstq.size() == 1 && startq.size() == 1)
      chk({tag, "_start_after_rst"}, 64'(startq[0]), 64'(rstq[0] + 1));
    chk({tag, "_ready_lat"}, 64'(ready_cyc), 64'(done_cyc + 1));
    chk({tag, "_memsel_fall"}, 64'(fall_cyc), 64'(ready_cyc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({oKeyReady, oL_we, oS_we, oMemSel, oMixRst, oMixStart, oSchedReady, oErr}), 64'd0);
    chk({tag, "_l"}, 64'({oL_address, oL_data}), 64'd0);
    chk({tag, "_s"}, 64'({oS_address, oS_data}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst = 1'b1; iRekey = 1'b0; iKeyValid = 1'b0; iKeyWord = '0; iMixDone = 1'b0;
    for (int k = 0; k < C; k++) keys[k] = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();
    chk("idle_keyready", 64'(oKeyReady), 64'd0);

    // Zero key, back-to-back words, long mixer.
    clear_rec();
    mix_lat = LAT1;
    rekey();
    chk("run1_keyready", 64'(oKeyReady), 64'd1);
    load_keys(1'b0);
    chk("run1_keyready_low", 64'(oKeyReady), 64'd0);
    wait_ready("run1");
    check_sched("run1");
    if (sq.size() == T) begin
      chk("s0_const", 64'(sq[0][31:0]), 64'h B7E15163);
      chk("s1_const", 64'(sq[1][31:0]), 64'h 5618CB1C);
      chk("s25_const", 64'(sq[25][31:0]), 64'h 2B4C3474);
    end else begin
      chk("s_const_count", 64'(sq.size()), 64'(T));
    end

    // Gapped key words; rekey during INIT_S must be ignored.
    clear_rec();
    mix_lat = $urandom_range(LMAX, LMIN);
    for (int k = 0; k < C; k++) keys[k] = $urandom;
    rekey();
    load_keys(1'b1);
    chk("run2_keyready_low", 64'(oKeyReady), 64'd0);
    rekey();
    chk("run2_rekey_ignored", 64'(oKeyReady), 64'd0);
    wait_ready("run2");
    check_sched("run2");

    // Rekey from READY.
    clear_rec();
    mix_lat = $urandom_range(LMAX, LMIN);
    for (int k = 0; k < C; k++) keys[k] = $urandom;
    rekey();
    chk("run3_ready_drop", 64'(oSchedReady), 64'd0);
    chk("run3_keyready", 64'(oKeyReady), 64'd1);
    load_keys(1'b0);
    wait_ready("run3");
    check_sched("run3");

    // Asynchronous reset in the middle of S initialisation.
    clear_rec();
    for (int k = 0; k < C; k++) keys[k] = $urandom;
    rekey();
    load_keys(1'b0);
    g = 0;
    while (sq.size() < 10 && g < 200) begin
      tick();
      g++;
    end
    chk("run4_s_progress", 64'(sq.size()), 64'd10);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    clear_rec();
    mix_lat = $urandom_range(LMAX, LMIN);
    rekey();
    load_keys(1'b0);
    g = 0;
    while (sq.size() < 1 && g < 50) begin
      tick();
      g++;
    end
    if (sq.size() >= 1) chk("run4_restart_s0", 64'(sq[0]), 64'({SAW'(0), P}));
    else chk("run4_restart_s0_seen", 64'(sq.size()), 64'd1);
    wait_ready("run4");
    check_sched("run4");

`ifdef KEYSCHED_WATCHDOG_EN
    // Mixer never finishes: timeout to IDLE with sticky error.
    clear_rec();
    mix_en = 1'b0;
    rekey();
    load_keys(1'b0);
    g = 0;
    while (!oErr && g < 200) begin
      tick();
      g++;
    end
    chk("wdog_err", 64'(oErr), 64'd1);
    if (startq.size() == 1) chk("wdog_time", 64'(err_cyc), 64'(startq[0] + WDOG));
    chk("wdog_memsel", 64'(oMemSel), 64'd0);
    tick(); tick(); tick();
    chk("wdog_sticky", 64'({oErr, oSchedReady, oKeyReady}), 64'b100);
    clear_rec();
    mix_en = 1'b1;
    mix_lat = LMIN;
    rekey();
    chk("wdog_err_clear", 64'(oErr), 64'd0);
    load_keys(1'b0);
    wait_ready("wdog_recover");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
